change_event_logger: RTL and testbench
======================================

CHANGE_EVENT_LOGGER -- requirements
Module: change_event_logger

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the FIFO entry count; it is a power of two, 2..16.
REQ-002 Parameter HOLD, default 8, SHALL set the number of alert stretch cycles; range 1..255.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 evt_valid  input  1  SHALL be the change-detected strobe from the comparator stage (its Q output).
REQ-006 evt_sensor  input  2  SHALL be the sensor ID of the event (comparator Q1); it is sampled only when evt_valid=1.
REQ-007 rd_en  input  1  SHALL be the pop request from the consumer.
REQ-008 clr_ovf  input  1  SHALL be a synchronous clear of the overflow flag.
REQ-009 cnt_sel  input  2  SHALL select the per-sensor counter driven on cnt_out.
REQ-010 dout  output  8  SHALL present the head entry as {sensor[1:0], timestamp[5:0]} (first-word fall-through).
REQ-011 empty  output  1  SHALL be high when the FIFO holds 0 entries.
REQ-012 full  output  1  SHALL be high when the FIFO holds DEPTH entries.
REQ-013 overflow  output  1  SHALL be a sticky flag indicating an event was dropped.
REQ-014 alert  output  1  SHALL be the stretched LED alert.
REQ-015 cnt_out  output  4  SHALL be the event count of sensor cnt_sel (combinational mux of registers).

Function
REQ-016 Timestamp: a 6-bit free-running counter SHALL increment every cycle and wrap 63->0.
REQ-017 Push: when evt_valid=1, the entry {evt_sensor, current timestamp} SHALL be written if not full, or if full and a pop is accepted in the same cycle.
REQ-018 Pop: rd_en=1 with empty=0 SHALL advance the read pointer; rd_en with empty=1 SHALL be ignored with no state change.
REQ-019 Simultaneous push and pop when empty: the push SHALL be accepted and the pop ignored; the count becomes 1.
REQ-020 Simultaneous push and pop when full: both SHALL be accepted; the count stays DEPTH and no overflow occurs.
REQ-021 Drop: evt_valid=1 while full with no accepted pop SHALL discard the entry and set overflow on the next edge.
REQ-022 overflow SHALL remain set until clr_ovf=1 or reset; when clr_ovf and a drop occur in the same cycle, set SHALL win.
REQ-023 Pointers SHALL be log2(DEPTH) bits, wrap modulo DEPTH, and use a separate (log2(DEPTH)+1)-bit occupancy count; empty and full SHALL derive from the count.
REQ-024 dout SHALL equal the head entry whenever empty=0; its value is don't-care when empty=1.
REQ-025 Counters: four 4-bit per-sensor counters SHALL increment on every evt_valid for evt_sensor (accepted or dropped) and saturate at 15.
REQ-026 Alert: an 8-bit hold counter SHALL load HOLD on any evt_valid, otherwise decrement toward 0 and stop there; alert = (hold counter != 0), registered.
REQ-027 Latency: alert and the occupancy change SHALL both take effect one clock after the evt_valid edge; a pushed entry SHALL appear on dout the cycle after the push.
REQ-028 Back-to-back evt_valid for N cycles SHALL push N entries (subject to full) with consecutive timestamps.

Reset
REQ-029 Reset SHALL clear the pointers, count, timestamp, counters, hold counter and overflow immediately: empty=1, full=0, overflow=0, alert=0, cnt_out=0.
REQ-030 Reset asserted mid-operation SHALL discard all queued entries; the first post-reset push SHALL carry the timestamp value present in its push cycle, counted from 0 at reset release.

Verification
REQ-031 Release reset; pulse evt_valid with sensor=2 at timestamp 5 -> next cycle empty=0, dout=8'b10_000101, alert=1; alert stays high for 8 cycles and then drops.
REQ-032 Push 4 events, then a 5th with rd_en=0 -> full=1, overflow=1, count=4, and dout still equals the first entry.
REQ-033 While full, apply evt_valid and rd_en together -> full stays 1, overflow stays 0, and the old head is replaced by the second entry.
REQ-034 With empty=1, apply evt_valid and rd_en together -> count=1 and dout equals the new entry.
REQ-035 Apply 20 events on sensor 3, then set cnt_sel=3 -> cnt_out=15; cnt_sel=0 -> cnt_out=0.
REQ-036 Assert reset with 3 entries queued and overflow=1 -> empty=1, overflow=0 and alert=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/change_event_logger.sv
// change_event_logger: timestamps change events from the comparator stage,
// queues them in a small first-word-fall-through FIFO, keeps saturating
// per-sensor event counts, a sticky drop flag and a stretched LED alert.
module change_event_logger #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       evt_valid,
    input  logic [1:0] evt_sensor,
    input  logic       rd_en,
    input  logic       clr_ovf,
    input  logic [1:0] cnt_sel,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full,
    output logic       overflow,
    output logic       alert,
    output logic [3:0] cnt_out
);

    localparam int DATA_W = 8;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [7:0]    HOLD_VAL = 8'(HOLD);

    // Saturating increment for the 4-bit per-sensor counters.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Hold counter step: reload on an event, otherwise run down and park at 0.
    function automatic logic [7:0] hold_next(input logic ev, input logic [7:0] v);
        if (ev)
            return HOLD_VAL;
        else if (v != 8'd0)
            return v - 8'd1;
        else
            return v;
    endfunction

    logic [5:0]        ts_q,     ts_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;
    logic              ovf_q,    ovf_d;
    logic [7:0]        hold_q,   hold_d;
    logic              alert_q,  alert_d;
    logic [3:0]        cnt_q [4];
    logic [3:0]        cnt_d [4];
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic is_empty;
    logic is_full;
    logic pop_acc;
    logic push_acc;
    logic drop;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FULL_CNT);

    // A pop only counts when there is something to pop; a push into a full
    // FIFO is still taken if the head leaves in the same cycle.
    assign pop_acc  = rd_en && !is_empty;
    assign push_acc = evt_valid && (!is_full || pop_acc);
    assign drop     = evt_valid && is_full && !pop_acc;

    // Next-state computation for timestamp, pointers, occupancy, flags and counters.
    always_comb begin
        ts_d     = ts_q + 6'd1;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_acc)
            wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_acc)
            rd_ptr_d = rd_ptr_q + 1'b1;

        unique case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear leaves the flag set.
        if (drop)
            ovf_d = 1'b1;
        else if (clr_ovf)
            ovf_d = 1'b0;
        else
            ovf_d = ovf_q;

        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (evt_valid && (evt_sensor == 2'(i)))
                cnt_d[i] = sat_inc4(cnt_q[i]);
        end

        hold_d  = hold_next(evt_valid, hold_q);
        alert_d = (hold_d != 8'd0);
    end

    // Control state: cleared immediately by reset, otherwise follows next-state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            hold_q   <= '0;
            alert_q  <= 1'b0;
            for (int i = 0; i < 4; i++)
                cnt_q[i] <= '0;
        end else begin
            ts_q     <= ts_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            hold_q   <= hold_d;
            alert_q  <= alert_d;
            for (int i = 0; i < 4; i++)
                cnt_q[i] <= cnt_d[i];
        end
    end

    // Entry storage: data only, so it is not reset; stale words are hidden by the count.
    always_ff @(posedge clk) begin
        if (push_acc)
            mem_q[wr_ptr_q] <= {evt_sensor, ts_q};
    end

    assign dout     = mem_q[rd_ptr_q];
    assign empty    = is_empty;
    assign full     = is_full;
    assign overflow = ovf_q;
    assign alert    = alert_q;
    assign cnt_out  = cnt_q[cnt_sel];

endmodule

// File: tb/tb_change_event_logger.sv
// Testbench for change_event_logger: directed vector table, hand-written
// reset/saturation sequences, then random traffic against a queue-based model.
module tb_change_event_logger;

    localparam int DEPTH = 4;
    localparam int HOLD  = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       evt_valid;
    logic [1:0] evt_sensor;
    logic       rd_en;
    logic       clr_ovf;
    logic [1:0] cnt_sel;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       alert;
    logic [3:0] cnt_out;

    change_event_logger #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
        .clk        (clk),
        .reset      (reset),
        .evt_valid  (evt_valid),
        .evt_sensor (evt_sensor),
        .rd_en      (rd_en),
        .clr_ovf    (clr_ovf),
        .cnt_sel    (cnt_sel),
        .dout       (dout),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .alert      (alert),
        .cnt_out    (cnt_out)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [7:0] mq[$];
    int         m_ts;
    int         m_hold;
    bit         m_ovf;
    int         m_cnt[4];

    typedef struct {
        logic       ev;
        logic [1:0] sen;
        logic       rd;
        logic       clr;
        logic [1:0] sel;
        logic       e_empty;
        logic       e_full;
        logic       e_ovf;
        logic       e_alert;
        logic       dv;
        logic [7:0] e_dout;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t tbl[30];

    function automatic vec_t mk(logic ev, logic [1:0] sen, logic rd, logic clr, logic [1:0] sel,
                                logic e_empty, logic e_full, logic e_ovf, logic e_alert,
                                logic dv, logic [7:0] e_dout, logic [3:0] e_cnt);
        vec_t v;
        v.ev = ev; v.sen = sen; v.rd = rd; v.clr = clr; v.sel = sel;
        v.e_empty = e_empty; v.e_full = e_full; v.e_ovf = e_ovf; v.e_alert = e_alert;
        v.dv = dv; v.e_dout = e_dout; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ts   = 0;
        m_hold = 0;
        m_ovf  = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic model_update(input logic ev, input logic [1:0] sen, input logic rd, input logic clr);
        bit was_full, was_empty, pop, push, dropped;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        pop       = rd && !was_empty;
        push      = ev && (!was_full || pop);
        dropped   = ev && was_full && !pop;
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back({sen, 6'(m_ts)});
        if (dropped)  m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (ev && m_cnt[sen] < 15) m_cnt[sen]++;
        if (ev)              m_hold = HOLD;
        else if (m_hold > 0) m_hold--;
        m_ts = (m_ts + 1) % 64;
    endtask

    task automatic model_check();
        chk("m_empty",    empty,    mq.size() == 0);
        chk("m_full",     full,     mq.size() == DEPTH);
        chk("m_overflow", overflow, m_ovf);
        chk("m_alert",    alert,    m_hold != 0);
        chk("m_cnt_out",  cnt_out,  m_cnt[cnt_sel]);
        if (mq.size() > 0) chk("m_dout", dout, mq[0]);
    endtask

    task automatic step(input logic ev, input logic [1:0] sen, input logic rd, input logic clr,
                        input logic [1:0] sel, input bit cm);
        evt_valid  = ev;
        evt_sensor = sen;
        rd_en      = rd;
        clr_ovf    = clr;
        cnt_sel    = sel;
        model_update(ev, sen, rd, clr);
        @(posedge clk);
        #1;
        if (cm) model_check();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 5; i++)   tbl[i] = mk(0,0,0,0,0, 1,0,0,0, 0,8'h00,0);
        tbl[5]  = mk(1,2,0,0,2, 0,0,0,1, 1,8'h85,1);
        for (int i = 6; i < 13; i++)  tbl[i] = mk(0,0,0,0,2, 0,0,0,1, 1,8'h85,1);
        tbl[13] = mk(0,0,0,0,2, 0,0,0,0, 1,8'h85,1);
        tbl[14] = mk(0,0,1,0,2, 1,0,0,0, 0,8'h00,1);
        tbl[15] = mk(1,1,0,0,1, 0,0,0,1, 1,8'h4F,1);
        tbl[16] = mk(1,1,0,0,1, 0,0,0,1, 1,8'h4F,2);
        tbl[17] = mk(1,1,0,0,1, 0,0,0,1, 1,8'h4F,3);
        tbl[18] = mk(1,1,0,0,1, 0,1,0,1, 1,8'h4F,4);
        tbl[19] = mk(1,0,0,0,1, 0,1,1,1, 1,8'h4F,4);
        tbl[20] = mk(0,0,0,1,1, 0,1,0,1, 1,8'h4F,4);
        tbl[21] = mk(1,3,1,0,3, 0,1,0,1, 1,8'h50,1);
        tbl[22] = mk(1,3,0,1,3, 0,1,1,1, 1,8'h50,2);
        tbl[23] = mk(0,0,1,0,3, 0,0,1,1, 1,8'h51,2);
        tbl[24] = mk(0,0,1,0,3, 0,0,1,1, 1,8'h52,2);
        tbl[25] = mk(0,0,1,0,3, 0,0,1,1, 1,8'hD5,2);
        tbl[26] = mk(0,0,1,0,3, 1,0,1,1, 0,8'h00,2);
        tbl[27] = mk(1,0,1,0,0, 0,0,1,1, 1,8'h1B,2);
        tbl[28] = mk(0,0,1,0,0, 1,0,1,1, 0,8'h00,2);
        tbl[29] = mk(0,0,1,1,0, 1,0,0,1, 0,8'h00,2);

        // Power-on reset
        reset = 1'b1; evt_valid = 0; evt_sensor = 0; rd_en = 0; clr_ovf = 0; cnt_sel = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty",    empty,    1);
        chk("rst_full",     full,     0);
        chk("rst_overflow", overflow, 0);
        chk("rst_alert",    alert,    0);
        chk("rst_cnt_out",  cnt_out,  0);
        reset = 1'b0;

        // Directed vector table
        for (int r = 0; r < 30; r++) begin
            step(tbl[r].ev, tbl[r].sen, tbl[r].rd, tbl[r].clr, tbl[r].sel, 1'b0);
            chk($sformatf("tbl%0d_empty", r),    empty,    tbl[r].e_empty);
            chk($sformatf("tbl%0d_full", r),     full,     tbl[r].e_full);
            chk($sformatf("tbl%0d_overflow", r), overflow, tbl[r].e_ovf);
            chk($sformatf("tbl%0d_alert", r),    alert,    tbl[r].e_alert);
            chk($sformatf("tbl%0d_cnt_out", r),  cnt_out,  tbl[r].e_cnt);
            if (tbl[r].dv) chk($sformatf("tbl%0d_dout", r), dout, tbl[r].e_dout);
        end

        // Fill past full, pop one: three entries queued with overflow set
        for (int i = 0; i < 5; i++) step(1, 2'd2, 0, 0, 2'd2, 1'b1);
        step(0, 0, 1, 0, 2'd2, 1'b1);
        chk("pre_rst_overflow", overflow, 1);
        chk("pre_rst_empty",    empty,    0);

        // Asynchronous reset mid-cycle, checked before any clock edge
        evt_valid = 0; rd_en = 0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_empty",    empty,    1);
        chk("async_rst_full",     full,     0);
        chk("async_rst_overflow", overflow, 0);
        chk("async_rst_alert",    alert,    0);
        chk("async_rst_cnt_out",  cnt_out,  0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // First push after reset carries the timestamp counted from release
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 2'd0, 1'b1);
        step(1, 2'd1, 0, 0, 2'd1, 1'b1);
        chk("post_rst_dout", dout, 8'h43);

        // Counter saturation on sensor 3
        for (int i = 0; i < 20; i++) step(1, 2'd3, 0, 0, 2'd3, 1'b1);
        cnt_sel = 2'd3;
        #1;
        chk("sat_cnt3", cnt_out, 15);
        cnt_sel = 2'd0;
        #1;
        chk("sat_cnt0", cnt_out, 0);

        // Random traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), $urandom_range(0, 9) < 4,
                 $urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
